// File: rtl/mux_reg_bank_pkg.sv
// Shared defaults and slice helper for the multiplexed register bank.
package mux_reg_bank_pkg;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 2;

  // Low bit of channel idx inside a packed CHANNELS*w bus.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/mux_reg_bank_cell.sv
// One WIDTH-bit channel register with async clear and load enable.
module mux_reg_bank_cell
  import mux_reg_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  // Conditional form so an unknown load enable smears x into the register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_q <= '0;
    else     r_q <= i_ld ? i_d : r_q;
  end

  assign o_q = r_q;
endmodule

// File: rtl/mux_reg_bank.sv
// CHANNELS x WIDTH register bank with direct/scan output select, real-time bypass and tri-state output.
module mux_reg_bank
  import mux_reg_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       ld,
  input  logic [SELW-1:0]           sel,
  input  logic                      scan,
  input  logic                      rt,
  input  logic                      oe_n,
  output wire  [WIDTH-1:0]          y,
  output logic [SELW-1:0]           cur,
  output logic                      wrap
);
  localparam logic [SELW:0]   NCH  = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] w_q;
  logic [SELW-1:0]                r_ptr;
  logic                           r_wrap;
  logic [SELW-1:0]                w_idx;
  logic [WIDTH-1:0]               w_data;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    mux_reg_bank_cell #(.WIDTH(WIDTH)) u_cell (
      .clk  (clk),
      .clr  (clr),
      .i_ld (ld[i]),
      .i_d  (d[slice_lo(i, WIDTH) +: WIDTH]),
      .o_q  (w_q[i])
    );
  end

  // Out of scan mode the pointer shadows sel, so scanning resumes from the last direct pick.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ptr  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= scan & (r_ptr == LAST);
      if (scan) r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
      else      r_ptr <= ({1'b0, sel} < NCH) ? sel : '0;
    end
  end

  assign w_idx = scan ? r_ptr : sel;

  always_comb begin
    w_data = '0;
    if ({1'b0, w_idx} < NCH)
      w_data = rt ? d[slice_lo(int'(w_idx), WIDTH) +: WIDTH] : w_q[w_idx];
  end

  assign y    = oe_n ? {WIDTH{1'bz}} : w_data;
  assign cur  = w_idx;
  assign wrap = r_wrap;
endmodule

// File: tb/tb_mux_reg_bank.sv
// Directed + random checks of a 2-channel and a 3-channel bank against an array/integer model.
module tb_mux_reg_bank;
  import mux_reg_bank_pkg::*;
  localparam int W = DEF_WIDTH;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int total = 0, bad = 0;

  logic [2*W-1:0] a_d;   logic [1:0] a_ld;  logic       a_sel;
  logic a_scan, a_rt, a_oen;
  wire  [W-1:0]   a_y;   logic       a_cur; logic       a_wrap;

  logic [3*W-1:0] b_d;   logic [2:0] b_ld;  logic [1:0] b_sel;
  logic b_scan, b_rt, b_oen;
  wire  [W-1:0]   b_y;   logic [1:0] b_cur; logic       b_wrap;

  logic [W-1:0] ma[2], mb[3];
  int pa, pb;
  bit wa, wb;

  mux_reg_bank u_a (
    .clk(clk), .clr(clr), .d(a_d), .ld(a_ld), .sel(a_sel), .scan(a_scan),
    .rt(a_rt), .oe_n(a_oen), .y(a_y), .cur(a_cur), .wrap(a_wrap)
  );

  mux_reg_bank #(.WIDTH(W), .CHANNELS(3)) u_b (
    .clk(clk), .clr(clr), .d(b_d), .ld(b_ld), .sel(b_sel), .scan(b_scan),
    .rt(b_rt), .oe_n(b_oen), .y(b_y), .cur(b_cur), .wrap(b_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ca();
    return a_scan ? pa : int'(a_sel);
  endfunction

  function automatic int cb();
    return b_scan ? pb : int'(b_sel);
  endfunction

  function automatic logic [W-1:0] ey_a();
    int idx = ca();
    if (a_oen) return {W{1'bz}};
    if (idx >= 2) return '0;
    return a_rt ? a_d[slice_lo(idx, W) +: W] : ma[idx];
  endfunction

  function automatic logic [W-1:0] ey_b();
    int idx = cb();
    if (b_oen) return {W{1'bz}};
    if (idx >= 3) return '0;
    return b_rt ? b_d[slice_lo(idx, W) +: W] : mb[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) ma[i] = '0;
    for (int i = 0; i < 3; i++) mb[i] = '0;
    pa = 0; pb = 0; wa = 0; wb = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".a_y"},    32'(a_y),    32'(ey_a()));
    chk({tag, ".a_cur"},  32'(a_cur),  32'(ca()));
    chk({tag, ".a_wrap"}, 32'(a_wrap), 32'(wa));
    chk({tag, ".b_y"},    32'(b_y),    32'(ey_b()));
    chk({tag, ".b_cur"},  32'(b_cur),  32'(cb()));
    chk({tag, ".b_wrap"}, 32'(b_wrap), 32'(wb));
  endtask

  // Model next state from pre-edge inputs, commit after the edge unless clear is held.
  task automatic tick();
    logic [W-1:0] na[2], nb[3];
    int npa, npb;
    bit nwa, nwb;
    for (int i = 0; i < 2; i++) na[i] = a_ld[i] ? a_d[slice_lo(i, W) +: W] : ma[i];
    for (int i = 0; i < 3; i++) nb[i] = b_ld[i] ? b_d[slice_lo(i, W) +: W] : mb[i];
    npa = a_scan ? ((pa + 1) % 2) : ((int'(a_sel) < 2) ? int'(a_sel) : 0);
    nwa = a_scan && (pa == 1);
    npb = b_scan ? ((pb + 1) % 3) : ((int'(b_sel) < 3) ? int'(b_sel) : 0);
    nwb = b_scan && (pb == 2);
    @(posedge clk);
    #1;
    if (!clr) begin
      ma = na; mb = nb; pa = npa; pb = npb; wa = nwa; wb = nwb;
    end
  endtask

  initial begin
    int exp_cur[5]  = '{2, 0, 1, 2, 0};
    int exp_y[5]    = '{3, 1, 2, 3, 1};
    int exp_wrap[5] = '{0, 1, 0, 0, 1};

    a_d = '0; a_ld = '0; a_sel = 1'b0; a_scan = 1'b0; a_rt = 1'b0; a_oen = 1'b0;
    b_d = '0; b_ld = '0; b_sel = '0;   b_scan = 1'b0; b_rt = 1'b0; b_oen = 1'b0;
    model_reset();
    #12 clr = 1'b0;
    #1;
    chk("rst_a_y", 32'(a_y), 32'h0);
    chk("rst_a_cur", 32'(a_cur), 32'h0);
    chk("rst_a_wrap", 32'(a_wrap), 32'h0);
    chk_all("rst");

    // Channel loads with x on the unloaded slice.
    a_ld = 2'b01; a_d = {{W{1'bx}}, 8'hAA}; tick();
    a_ld = 2'b10; a_d = {8'hCC, {W{1'bx}}}; tick();
    a_ld = 2'b00; a_d = {2*W{1'bx}};
    a_sel = 1'b0; #1 chk("a_sel0", 32'(a_y), 32'hAA);
    a_sel = 1'b1; #1 chk("a_sel1", 32'(a_y), 32'hCC);
    chk_all("ld");

    // Real-time bypass and tri-state, no clock.
    a_rt = 1'b1; a_d[15:8] = 8'hF0; #1 chk("a_rt", 32'(a_y), 32'hF0);
    a_rt = 1'b0; #1 chk("a_stored", 32'(a_y), 32'hCC);
    a_oen = 1'b1; #1 chk("a_oe", 32'(a_y), 32'(ey_a()));
    a_oen = 1'b0; a_d = '0;

    // Three-channel scan starting from sel=1.
    b_ld = 3'b111; b_d = {8'h03, 8'h02, 8'h01}; tick();
    b_ld = '0; b_sel = 2'd1; tick();
    b_scan = 1'b1; #1 chk("b_scan_start", 32'(b_cur), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("b_scan_cur%0d", k), 32'(b_cur), 32'(exp_cur[k]));
      chk($sformatf("b_scan_y%0d", k), 32'(b_y), 32'(exp_y[k]));
      chk($sformatf("b_scan_wrap%0d", k), 32'(b_wrap), 32'(exp_wrap[k]));
      chk_all("scan");
    end

    // Clear mid-scan at cur=2.
    b_sel = 2'd3; tick(); tick();
    chk("b_pre_clr", 32'(b_cur), 32'd2);
    clr = 1'b1; #1;
    model_reset();
    chk("clr_b_y", 32'(b_y), 32'h0);
    chk("clr_b_cur", 32'(b_cur), 32'h0);
    chk("clr_b_wrap", 32'(b_wrap), 32'h0);
    b_ld = 3'b111; b_d = {8'h5A, 8'h6B, 8'h7C}; a_ld = 2'b11; a_d = 16'h1234;
    tick(); tick();
    chk("clr_edges_cur", 32'(b_cur), 32'h0);
    chk_all("clr_edges");
    b_scan = 1'b0;
    for (int s = 0; s < 3; s++) begin
      b_sel = 2'(s); #1 chk($sformatf("clr_reg%0d", s), 32'(b_y), 32'h0);
    end
    b_rt = 1'b1; b_sel = 2'd0; #1 chk("clr_rt", 32'(b_y), 32'h7C);
    b_rt = 1'b0; b_ld = '0; a_ld = '0; b_scan = 1'b1;
    clr = 1'b0; #1;
    tick();
    chk("post_clr_cur", 32'(b_cur), 32'd1);
    chk_all("post_clr");

    // Out-of-range direct select.
    b_scan = 1'b0; b_sel = 2'd3; #1;
    chk("oor_y", 32'(b_y), 32'h0);
    chk("oor_cur", 32'(b_cur), 32'd3);
    b_rt = 1'b1; b_d = 24'hFFFFFF; #1 chk("oor_rt_y", 32'(b_y), 32'h0);
    b_rt = 1'b0;
    tick();
    b_scan = 1'b1; tick();
    chk("oor_next_cur", 32'(b_cur), 32'd1);

    // Randomised traffic with occasional clears between edges.
    for (int n = 0; n < 400; n++) begin
      a_d = 16'($urandom); a_ld = 2'($urandom); a_sel = 1'($urandom);
      a_scan = ($urandom_range(0, 3) != 0); a_rt = 1'($urandom); a_oen = ($urandom_range(0, 7) == 0);
      b_d = 24'($urandom); b_ld = 3'($urandom); b_sel = 2'($urandom_range(0, 3));
      b_scan = ($urandom_range(0, 3) != 0); b_rt = 1'($urandom); b_oen = ($urandom_range(0, 7) == 0);
      #1 chk_all("rnd_pre");
      tick();
      chk_all("rnd_post");
      if ($urandom_range(0, 39) == 0) begin
        clr = 1'b1; #1;
        model_reset();
        chk_all("rnd_clr");
        clr = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
